// File: rtl/mac_booth_r4.sv
// Multiply-accumulate unit: sequential radix-4 Booth multiplier (two bits per cycle)
// feeding a wrapping or saturating accumulator with a sticky overflow flag.
module mac_booth_r4 #(
  parameter int DATA_WIDTH = 16,
  parameter int OUT_WIDTH  = 32,
  parameter bit SATURATE   = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  signed_mode,
  input  logic                  acc_clr,
  output logic [OUT_WIDTH-1:0]  out,
  output logic                  out_valid,
  output logic                  overflow
);

  localparam int EW   = DATA_WIDTH + 2;
  localparam int PW   = 2 * EW;
  localparam int ITER = DATA_WIDTH / 2 + 1;
  localparam int CW   = $clog2(ITER + 1);

  typedef enum logic [1:0] {IDLE, MUL, ACC} state_t;

  state_t               state_reg, state_next;
  logic [PW-1:0]        mcand_reg;
  logic [EW:0]          mplr_reg;
  logic [PW-1:0]        prod_reg;
  logic [CW-1:0]        cnt_reg;
  logic                 mode_reg;
  logic                 clr_reg;
  logic [OUT_WIDTH-1:0] out_reg;
  logic                 valid_reg;
  logic                 ovf_reg;

  logic [PW-1:0]        pp;
  logic [OUT_WIDTH-1:0] prod_ext;
  logic [OUT_WIDTH-1:0] base;
  logic [OUT_WIDTH:0]   sum;
  logic                 s_ovf;
  logic                 ovf_evt;
  logic [OUT_WIDTH-1:0] acc_next;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid) state_next = MUL;
      MUL:     if (cnt_reg == CW'(ITER - 1)) state_next = ACC;
      ACC:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Booth digit from the current triplet; the multiplicand is pre-shifted each step.
  always_comb begin
    pp = '0;
    case (mplr_reg[2:0])
      3'b001, 3'b010: pp = mcand_reg;
      3'b011:         pp = mcand_reg << 1;
      3'b100:         pp = -(mcand_reg << 1);
      3'b101, 3'b110: pp = -mcand_reg;
      default:        pp = '0;
    endcase
  end

  // The full product is exact two's complement in both modes (unsigned operands
  // are zero-extended, so the product is non-negative); sign extension covers both.
  generate
    if (OUT_WIDTH > PW) begin : g_ext
      assign prod_ext = {{(OUT_WIDTH-PW){prod_reg[PW-1]}}, prod_reg};
    end else begin : g_trunc
      assign prod_ext = prod_reg[OUT_WIDTH-1:0];
      if (OUT_WIDTH < PW) begin : g_hi
        logic unused_prod_hi;
        assign unused_prod_hi = ^prod_reg[PW-1:OUT_WIDTH];
      end
    end
  endgenerate

  always_comb begin
    base     = clr_reg ? '0 : out_reg;
    sum      = {1'b0, base} + {1'b0, prod_ext};
    s_ovf    = (base[OUT_WIDTH-1] == prod_ext[OUT_WIDTH-1]) &&
               (sum[OUT_WIDTH-1] != base[OUT_WIDTH-1]);
    ovf_evt  = mode_reg ? s_ovf : sum[OUT_WIDTH];
    acc_next = sum[OUT_WIDTH-1:0];
    if (SATURATE && ovf_evt) begin
      if (!mode_reg)                  acc_next = '1;
      else if (prod_ext[OUT_WIDTH-1]) acc_next = {1'b1, {(OUT_WIDTH-1){1'b0}}};
      else                            acc_next = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcand_reg <= '0;
      mplr_reg  <= '0;
      prod_reg  <= '0;
      cnt_reg   <= '0;
      mode_reg  <= 1'b0;
      clr_reg   <= 1'b0;
      out_reg   <= '0;
      valid_reg <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            mcand_reg <= {{(PW-DATA_WIDTH){signed_mode & a[DATA_WIDTH-1]}}, a};
            mplr_reg  <= {{2{signed_mode & b[DATA_WIDTH-1]}}, b, 1'b0};
            prod_reg  <= '0;
            cnt_reg   <= '0;
            mode_reg  <= signed_mode;
            clr_reg   <= acc_clr;
          end else if (acc_clr) begin
            out_reg <= '0;
            ovf_reg <= 1'b0;
          end
        end
        MUL: begin
          prod_reg  <= prod_reg + pp;
          mcand_reg <= mcand_reg << 2;
          mplr_reg  <= {2'b00, mplr_reg[EW:2]};
          cnt_reg   <= cnt_reg + CW'(1);
        end
        ACC: begin
          out_reg   <= acc_next;
          valid_reg <= 1'b1;
          ovf_reg   <= (ovf_reg & ~clr_reg) | ovf_evt;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out       = out_reg;
  assign out_valid = valid_reg;
  assign overflow  = ovf_reg;

endmodule

// File: tb/tb_mac_booth_r4.sv
// Directed bench for mac_booth_r4: a saturating and a wrapping instance share stimulus;
// a wide-integer accumulator model feeds a scoreboard queue checked on each out_valid.
module tb_mac_booth_r4;

  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;
  localparam longint UMAX = 64'sd4294967295;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        signed_mode;
  logic        acc_clr;
  logic [15:0] a, b;
  logic        rdy_s, rdy_w, vld_s, vld_w, ovf_s, ovf_w;
  logic [31:0] out_s, out_w;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] out_s;
    logic [31:0] out_w;
    logic        ovf_s;
    logic        ovf_w;
  } exp_t;
  exp_t sb[$];

  logic [31:0] m_acc[2];
  bit          m_ovf[2];

  always #5 clk = ~clk;

  mac_booth_r4 #(.DATA_WIDTH(16), .OUT_WIDTH(32), .SATURATE(1'b1)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_s), .a(a), .b(b),
    .signed_mode(signed_mode), .acc_clr(acc_clr), .out(out_s), .out_valid(vld_s),
    .overflow(ovf_s)
  );

  mac_booth_r4 #(.DATA_WIDTH(16), .OUT_WIDTH(32), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_w), .a(a), .b(b),
    .signed_mode(signed_mode), .acc_clr(acc_clr), .out(out_w), .out_valid(vld_w),
    .overflow(ovf_w)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Index 0 models the saturating instance, index 1 the wrapping one.
  task automatic model_op(input logic [15:0] ia, input logic [15:0] ib, input bit sm, input bit clr);
    longint p, bs, s;
    bit     o;
    logic [31:0] r;
    exp_t   e;
    p = sm ? (longint'($signed(ia)) * longint'($signed(ib))) : (longint'(ia) * longint'(ib));
    for (int i = 0; i < 2; i++) begin
      if (clr)     bs = 0;
      else if (sm) bs = longint'($signed(m_acc[i]));
      else         bs = longint'(m_acc[i]);
      s = bs + p;
      o = sm ? ((s > SMAX) || (s < SMIN)) : (s > UMAX);
      r = s[31:0];
      if (i == 0 && o) r = sm ? ((s > 0) ? 32'h7FFFFFFF : 32'h80000000) : 32'hFFFFFFFF;
      m_acc[i] = r;
      m_ovf[i] = (clr ? 1'b0 : m_ovf[i]) | o;
    end
    e.out_s = m_acc[0];
    e.out_w = m_acc[1];
    e.ovf_s = m_ovf[0];
    e.ovf_w = m_ovf[1];
    sb.push_back(e);
  endtask

  // Called at a falling edge; returns at a falling edge.
  task automatic run_op(input logic [15:0] ia, input logic [15:0] ib, input bit sm,
                        input bit clr, input bit hold, input string tag);
    int   lat, low;
    exp_t e;
    chk({tag, "/ready"}, 64'(rdy_s), 64'd1);
    in_valid = 1'b1; a = ia; b = ib; signed_mode = sm; acc_clr = clr;
    @(posedge clk);
    model_op(ia, ib, sm, clr);
    lat = -1;
    low = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (vld_s || vld_w) begin
        lat = k;
        break;
      end
      if (!rdy_s) low++;
      if (hold) begin
        a = 16'($urandom); b = 16'($urandom);
        signed_mode = 1'($urandom); acc_clr = 1'($urandom);
      end else begin
        in_valid = 1'b0; acc_clr = 1'b0;
      end
    end
    in_valid = 1'b0;
    acc_clr  = 1'b0;
    chk({tag, "/latency"}, 64'(lat), 64'd10);
    chk({tag, "/busy"}, 64'(low), 64'd10);
    chk({tag, "/vld_w"}, 64'(vld_w), 64'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "/out_sat"}, 64'(out_s), 64'(e.out_s));
      chk({tag, "/out_wrap"}, 64'(out_w), 64'(e.out_w));
      chk({tag, "/ovf_sat"}, 64'(ovf_s), 64'(e.ovf_s));
      chk({tag, "/ovf_wrap"}, 64'(ovf_w), 64'(e.ovf_w));
    end else begin
      chk({tag, "/sb_empty"}, 64'(sb.size()), 64'd1);
    end
    @(negedge clk);
    chk({tag, "/pulse"}, 64'(vld_s | vld_w), 64'd0);
  endtask

  task automatic idle_clear();
    acc_clr = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    acc_clr = 1'b0;
    chk("clr/out_sat", 64'(out_s), 64'd0);
    chk("clr/out_wrap", 64'(out_w), 64'd0);
    chk("clr/ovf", 64'({ovf_s, ovf_w}), 64'd0);
    chk("clr/no_pulse", 64'(vld_s | vld_w), 64'd0);
    for (int i = 0; i < 2; i++) begin
      m_acc[i] = '0;
      m_ovf[i] = 1'b0;
    end
  endtask

  // Starts an op, asserts reset mid-MUL, then releases reset at a falling edge.
  task automatic mid_reset();
    in_valid = 1'b1; a = 16'd3; b = 16'd3; signed_mode = 1'b1; acc_clr = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mrst/busy", 64'(rdy_s), 64'd0);
    rst = 1'b0;
    #1;
    chk("mrst/out", 64'({out_s, out_w}), 64'd0);
    chk("mrst/ready", 64'({rdy_s, rdy_w}), 64'd3);
    chk("mrst/vld", 64'({vld_s, vld_w}), 64'd0);
    chk("mrst/ovf", 64'({ovf_s, ovf_w}), 64'd0);
    for (int i = 0; i < 2; i++) begin
      m_acc[i] = '0;
      m_ovf[i] = 1'b0;
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; signed_mode = 1'b0; acc_clr = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_acc[i] = '0;
      m_ovf[i] = 1'b0;
    end
    #2 rst = 1'b0;
    #1;
    chk("rst/out", 64'({out_s, out_w}), 64'd0);
    chk("rst/out_valid", 64'({vld_s, vld_w}), 64'd0);
    chk("rst/in_ready", 64'({rdy_s, rdy_w}), 64'd3);
    chk("rst/overflow", 64'({ovf_s, ovf_w}), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    run_op(16'hFFFD, 16'h0007, 1'b1, 1'b1, 1'b0, "neg3x7");
    run_op(16'h0005, 16'h0005, 1'b1, 1'b0, 1'b0, "acc5x5");
    mid_reset();
    run_op(16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 1'b0, "umax");
    run_op(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b0, "uovf");
    idle_clear();
    run_op(16'h8000, 16'h8000, 1'b1, 1'b1, 1'b0, "smin2");
    run_op(16'h7FFF, 16'h7FFF, 1'b1, 1'b1, 1'b0, "smax1");
    run_op(16'h7FFF, 16'h7FFF, 1'b1, 1'b0, 1'b0, "smax2");
    run_op(16'h7FFF, 16'h7FFF, 1'b1, 1'b0, 1'b0, "smax3");
    run_op(16'h0001, 16'h0001, 1'b1, 1'b0, 1'b0, "sticky");
    run_op(16'hFFFF, 16'h0001, 1'b1, 1'b1, 1'b0, "clrop");
    run_op(16'h8000, 16'h7FFF, 1'b1, 1'b1, 1'b0, "nsat1");
    run_op(16'h8000, 16'h7FFF, 1'b1, 1'b0, 1'b0, "nsat2");
    run_op(16'h8000, 16'h7FFF, 1'b1, 1'b0, 1'b0, "nsat3");
    run_op(16'h1234, 16'h0ABC, 1'b1, 1'b1, 1'b1, "hold");
    for (int i = 0; i < 6; i++)
      run_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b0, "rand");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
